// File: rtl/l2_cache_control.sv
// l2_cache_control: sequencing FSM for the 4-way write-back L2 cache.
// Handles tag lookup, hit service, pseudo-LRU victim choice, dirty-victim
// capture into the evict buffer, line fill and deferred write-back.
// Handshake: mem_read/mem_write are held by L1 until the one-cycle mem_resp
// pulse; pmem_read/pmem_write are held by this block until the one-cycle
// pmem_resp pulse, and pmem_resp in any other state is ignored.
module l2_cache_control #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             mem_read,
   input  logic             mem_write,
   output logic             mem_resp,
   output logic             pmem_read,
   output logic             pmem_write,
   input  logic             pmem_resp,
   input  logic             hit,
   input  logic [3:0]       tag_valid,
   input  logic [3:0]       dirty,
   input  logic [2:0]       lru,
   input  logic             evictreq,
   output logic             ld_hit,
   output logic             ld_lru,
   output logic             ld_evict,
   output logic             ld_evictreq,
   output logic [3:0]       ld_way,
   output logic [3:0]       ld_valid,
   output logic [3:0]       ld_tag,
   output logic [3:0]       ld_dirty,
   output logic [3:0]       dirty_in,
   output logic [3:0]       way_sel,
   output logic [1:0]       datamux_sel,
   output logic [1:0]       evictaddrmux_sel,
   output logic [2:0]       readaddrmux_sel,
   output logic             addrmux_sel,
   output logic             wdatamux_sel,
   output logic [CNT_W-1:0] hit_count,
   output logic [CNT_W-1:0] miss_count,
   output logic [2:0]       state_dbg
);

   localparam logic [2:0] S_INIT  = 3'd0;
   localparam logic [2:0] S_IDLE  = 3'd1;
   localparam logic [2:0] S_CHECK = 3'd2;
   localparam logic [2:0] S_EVICT = 3'd3;
   localparam logic [2:0] S_ALLOC = 3'd4;
   localparam logic [2:0] S_WB    = 3'd5;

   logic [2:0] state;
   logic [2:0] state_nxt;
   logic [1:0] victim;
   logic [1:0] victim_q;
   logic [1:0] hit_way;
   logic [3:0] hit_oh;
   logic [3:0] victim_oh;
   // refill: the current request already missed once (counted as a miss),
   // so its later re-lookup hit must not be counted as a hit
   logic       refill;

   assign state_dbg = state;
   assign hit_oh    = 4'b0001 << hit_way;
   assign victim_oh = 4'b0001 << victim_q;

   // pseudo-LRU victim from the live LRU bits of the current index
   always_comb begin
      victim = 2'd0;
      if (lru[2]) victim = lru[0] ? 2'd3 : 2'd2;
      else        victim = lru[1] ? 2'd1 : 2'd0;
   end

   // encode the registered per-way hit vector into a way index
   always_comb begin
      hit_way = 2'd0;
      if      (tag_valid[3]) hit_way = 2'd3;
      else if (tag_valid[2]) hit_way = 2'd2;
      else if (tag_valid[1]) hit_way = 2'd1;
      else                   hit_way = 2'd0;
   end

   // next state plus all datapath strobes; everything is 0 while reset is held
   always_comb begin
      state_nxt        = state;
      mem_resp         = 1'b0;
      pmem_read        = 1'b0;
      pmem_write       = 1'b0;
      ld_hit           = 1'b0;
      ld_lru           = 1'b0;
      ld_evict         = 1'b0;
      ld_evictreq      = 1'b0;
      ld_way           = 4'b0000;
      ld_valid         = 4'b0000;
      ld_tag           = 4'b0000;
      ld_dirty         = 4'b0000;
      dirty_in         = 4'b0000;
      way_sel          = 4'b0000;
      datamux_sel      = 2'd0;
      evictaddrmux_sel = 2'd0;
      readaddrmux_sel  = 3'd0;
      addrmux_sel      = 1'b0;
      wdatamux_sel     = 1'b0;
      if (rst_n) begin
         case (state)
            S_INIT: begin
               // ld_evictreq with ld_evict=0 clears a stale pending write-back
               ld_evictreq = 1'b1;
               state_nxt   = S_IDLE;
            end
            S_IDLE: begin
               if (mem_read || mem_write) begin
                  ld_hit    = 1'b1;
                  state_nxt = S_CHECK;
               end
            end
            S_CHECK: begin
               if (hit) begin
                  datamux_sel = hit_way;
                  mem_resp    = 1'b1;
                  ld_lru      = 1'b1;
                  if (mem_write) begin
                     ld_way   = hit_oh;
                     ld_dirty = hit_oh;
                     dirty_in = hit_oh;
                  end
                  state_nxt = evictreq ? S_WB : S_IDLE;
               end else if (evictreq) begin
                  state_nxt = S_WB;
               end else if (dirty[victim]) begin
                  state_nxt = S_EVICT;
               end else begin
                  state_nxt = S_ALLOC;
               end
            end
            S_EVICT: begin
               datamux_sel      = victim_q;
               evictaddrmux_sel = victim_q;
               ld_evict         = 1'b1;
               ld_evictreq      = 1'b1;
               state_nxt        = S_ALLOC;
            end
            S_ALLOC: begin
               pmem_read = 1'b1;
               if (pmem_resp) begin
                  ld_way    = victim_oh;
                  way_sel   = victim_oh;
                  ld_valid  = victim_oh;
                  ld_tag    = victim_oh;
                  ld_dirty  = victim_oh;
                  state_nxt = S_IDLE;
               end
            end
            S_WB: begin
               pmem_write   = 1'b1;
               addrmux_sel  = 1'b1;
               wdatamux_sel = 1'b1;
               if (pmem_resp) begin
                  ld_evictreq = 1'b1;
                  state_nxt   = S_IDLE;
               end
            end
            default: state_nxt = S_INIT;
         endcase
      end
   end

   // state, latched victim, refill flag and saturating performance counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_INIT;
         victim_q   <= 2'd0;
         refill     <= 1'b0;
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         state <= state_nxt;
         if (state == S_CHECK) begin
            if (hit) begin
               if (!refill && hit_count != {CNT_W{1'b1}})
                  hit_count <= hit_count + 1'b1;
               refill <= 1'b0;
            end else begin
               if (!refill && miss_count != {CNT_W{1'b1}})
                  miss_count <= miss_count + 1'b1;
               refill   <= 1'b1;
               victim_q <= victim;
            end
         end
         if (state == S_ALLOC && pmem_resp)
            refill <= 1'b1;
      end
   end

endmodule

// File: tb/tb_l2_cache_control.sv
// tb_l2_cache_control: directed bench for the L2 sequencing FSM with a
// response scoreboard; counters are narrowed to 2 bits to reach saturation.
module tb_l2_cache_control;

  localparam int CNT_W = 2;
  localparam logic [2:0] ST_INIT = 3'd0;
  localparam logic [2:0] ST_IDLE = 3'd1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             mem_read, mem_write, pmem_resp, hit, evictreq;
  logic [3:0]       tag_valid, dirty;
  logic [2:0]       lru;
  logic             mem_resp, pmem_read, pmem_write;
  logic             ld_hit, ld_lru, ld_evict, ld_evictreq;
  logic [3:0]       ld_way, ld_valid, ld_tag, ld_dirty, dirty_in, way_sel;
  logic [1:0]       datamux_sel, evictaddrmux_sel;
  logic [2:0]       readaddrmux_sel;
  logic             addrmux_sel, wdatamux_sel;
  logic [CNT_W-1:0] hit_count, miss_count;
  logic [2:0]       state_dbg;

  int tests = 0;
  int fails = 0;
  // scoreboard entry: {write response, expected datamux_sel}
  logic [2:0] exp_q[$];

  l2_cache_control #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp),
    .hit(hit), .tag_valid(tag_valid), .dirty(dirty), .lru(lru), .evictreq(evictreq),
    .ld_hit(ld_hit), .ld_lru(ld_lru), .ld_evict(ld_evict), .ld_evictreq(ld_evictreq),
    .ld_way(ld_way), .ld_valid(ld_valid), .ld_tag(ld_tag), .ld_dirty(ld_dirty),
    .dirty_in(dirty_in), .way_sel(way_sel),
    .datamux_sel(datamux_sel), .evictaddrmux_sel(evictaddrmux_sel),
    .readaddrmux_sel(readaddrmux_sel), .addrmux_sel(addrmux_sel),
    .wdatamux_sel(wdatamux_sel),
    .hit_count(hit_count), .miss_count(miss_count), .state_dbg(state_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one step: move to the next falling edge
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    mem_read = 0; mem_write = 0; pmem_resp = 0; hit = 0; evictreq = 0;
    tag_valid = 4'b0; dirty = 4'b0; lru = 3'b0;
  endtask

  // scoreboard: pop and compare whenever the DUT answers L1
  always @(negedge clk) begin
    #2;
    if (rst_n && mem_resp) begin
      if (exp_q.size() == 0) chk("unexpected_resp", 1, 0);
      else chk("resp", {|ld_dirty, datamux_sel}, exp_q.pop_front());
    end
  end

  // read or write hit on way index w, request seen in IDLE
  task automatic do_hit(input logic wr, input logic [1:0] w, input string tag);
    mem_read = ~wr; mem_write = wr;
    exp_q.push_back({wr, w});
    #1 chk({tag, "_ld_hit"}, ld_hit, 1);
    tick(); hit = 1; tag_valid = 4'b0001 << w;
    #1 chk({tag, "_mem_resp"}, mem_resp, 1);
    chk({tag, "_ld_lru"}, ld_lru, 1);
    tick(); clear_inputs();
    #1 chk({tag, "_back_idle"}, state_dbg, ST_IDLE);
  endtask

  initial begin
    clear_inputs();
    rst_n = 0;
    tick(); tick();
    #1 chk("rst_outputs", {mem_resp, pmem_read, pmem_write, ld_evictreq, ld_hit}, 0);
    // reset release: one INIT cycle
    tick(); rst_n = 1;
    #1 chk("init_state", state_dbg, ST_INIT);
    chk("init_ld_evictreq", ld_evictreq, 1);
    chk("init_ld_evict", ld_evict, 0);
    chk("init_others", {mem_resp, pmem_read, pmem_write, ld_hit, ld_lru, ld_way}, 0);
    tick();
    #1 chk("idle_after_init", state_dbg, ST_IDLE);
    chk("idle_ld_evictreq", ld_evictreq, 0);

    // read hit way3
    do_hit(1'b0, 2'd2, "rd_hit_w3");
    chk("hit_count_1", hit_count, 1);

    // write hit way1
    mem_write = 1; exp_q.push_back({1'b1, 2'd0});
    tick(); hit = 1; tag_valid = 4'b0001;
    #1 chk("wr_ld_way", ld_way, 4'b0001);
    chk("wr_ld_dirty", ld_dirty, 4'b0001);
    chk("wr_dirty_in", dirty_in, 4'b0001);
    chk("wr_way_sel", way_sel, 4'b0000);
    chk("wr_mem_resp", mem_resp, 1);
    tick(); clear_inputs();
    #1 chk("hit_count_2", hit_count, 2);

    // clean miss, lru=100 -> way3
    mem_read = 1; lru = 3'b100; exp_q.push_back({1'b0, 2'd2});
    tick();
    #1 chk("cm_no_resp", {mem_resp, ld_lru}, 0);
    tick(); lru = 3'b000;
    #1 chk("cm_pmem_read", pmem_read, 1);
    chk("cm_sels", {addrmux_sel, readaddrmux_sel}, 0);
    for (int i = 0; i < 4; i++) tick();
    pmem_resp = 1;
    #1 chk("cm_fill_pmem_read", pmem_read, 1);
    chk("cm_ld_way", ld_way, 4'b0100);
    chk("cm_way_sel", way_sel, 4'b0100);
    chk("cm_ld_valid_tag", {ld_valid, ld_tag}, 8'h44);
    chk("cm_ld_dirty", ld_dirty, 4'b0100);
    chk("cm_dirty_in", dirty_in, 4'b0000);
    tick(); pmem_resp = 0;
    #1 chk("cm_relookup", ld_hit, 1);
    tick(); hit = 1; tag_valid = 4'b0100;
    #1 chk("cm_resp", mem_resp, 1);
    tick(); clear_inputs();
    #1 chk("cm_miss_count", miss_count, 1);
    chk("cm_hit_count", hit_count, 2);

    // dirty miss, lru=010 -> way2 dirty
    mem_read = 1; lru = 3'b010; dirty = 4'b0010; exp_q.push_back({1'b0, 2'd1});
    tick();
    #1 chk("dm_no_resp", mem_resp, 0);
    tick(); lru = 3'b000;
    #1 chk("dm_evict", {ld_evict, ld_evictreq}, 2'b11);
    chk("dm_evict_sels", {datamux_sel, evictaddrmux_sel}, 4'b0101);
    tick(); evictreq = 1; dirty = 4'b0; pmem_resp = 1;
    #1 chk("dm_alloc", {pmem_read, pmem_write}, 2'b10);
    chk("dm_fill_way", {ld_way, ld_valid}, 8'h22);
    tick(); pmem_resp = 0;
    #1 chk("dm_relookup", ld_hit, 1);
    tick(); hit = 1; tag_valid = 4'b0010;
    #1 chk("dm_resp", mem_resp, 1);
    tick(); mem_read = 0; hit = 0; tag_valid = 4'b0;
    #1 chk("dm_wb", {pmem_write, addrmux_sel, wdatamux_sel, pmem_read}, 4'b1110);
    tick(); pmem_resp = 1;
    #1 chk("dm_wb_done", {ld_evictreq, ld_evict}, 2'b10);
    tick(); pmem_resp = 1; evictreq = 0;
    #1 chk("dm_idle", state_dbg, ST_IDLE);
    chk("stray_pmem_resp", {pmem_read, pmem_write, ld_evictreq}, 0);
    tick(); pmem_resp = 0;
    #1 chk("stray_still_idle", state_dbg, ST_IDLE);
    chk("dm_counts", {hit_count, miss_count}, {2'd2, 2'd2});

    // random-way read hits drive hit_count into saturation
    for (int k = 0; k < 2; k++) do_hit(1'b0, 2'($urandom_range(0, 3)), "rand_hit");
    chk("hit_count_sat", hit_count, 3);

    // reset during ALLOC
    mem_read = 1; lru = 3'b000;
    tick();
    tick();
    #1 chk("rst_alloc_pmem_read", pmem_read, 1);
    chk("miss_count_sat", miss_count, 3);
    #2 rst_n = 0; mem_read = 0;
    #1 chk("rst_drop_pmem", {pmem_read, pmem_write, mem_resp}, 0);
    tick(); rst_n = 1;
    #1 chk("rst2_init", {state_dbg, ld_evictreq}, {ST_INIT, 1'b1});
    chk("rst2_counters", {hit_count, miss_count}, 0);
    tick();
    #1 chk("rst2_idle", state_dbg, ST_IDLE);
    tick();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
